sevenseg_scan_controller: RTL and testbench

//  Time-multiplexed scan controller for a multi-digit common-bus 7-segment display.

---
 rtl/sevenseg_pkg.sv | 26 ++
 rtl/sevenseg_glyph_decode.sv | 41 ++++
 rtl/sevenseg_scan_controller.sv | 163 ++++++++++++++++
 tb/tb_sevenseg_scan_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package sevenseg_pkg;

  // One display digit as held in the shadow and active banks.
  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       blank;
  } digit_t;

  // Bit position of the decimal point on the segment bus.
  localparam int SEG_DP = 7;

  // Segment bus value that drives every segment dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Every bank entry powers up as a dark digit with the decimal point off.
  localparam digit_t DIGIT_RESET = '{nibble: 4'h0, dp: 1'b0, blank: 1'b1};

  // Scan sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational glyph decoder: one stored digit to its segment pattern.
// Segments a..g sit on seg[6:0], the decimal point on seg[SEG_DP], all active high.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  digit_t     digit,
  output logic [7:0] seg
);

  logic [6:0] shape;

  // Hex character shapes for 0..F.
  always_comb begin
    case (digit.nibble)
      4'h0:    shape = 7'h3F;
      4'h1:    shape = 7'h06;
      4'h2:    shape = 7'h5B;
      4'h3:    shape = 7'h4F;
      4'h4:    shape = 7'h66;
      4'h5:    shape = 7'h6D;
      4'h6:    shape = 7'h7D;
      4'h7:    shape = 7'h07;
      4'h8:    shape = 7'h7F;
      4'h9:    shape = 7'h6F;
      4'hA:    shape = 7'h77;
      4'hB:    shape = 7'h7C;
      4'hC:    shape = 7'h39;
      4'hD:    shape = 7'h5E;
      4'hE:    shape = 7'h79;
      default: shape = 7'h71;
    endcase
  end

  // A blanked digit darkens its segments but keeps its decimal point.
  always_comb begin
    seg         = SEG_OFF;
    seg[6:0]    = digit.blank ? 7'h00 : shape;
    seg[SEG_DP] = digit.dp;
  end

endmodule

// File: rtl/sevenseg_scan_controller.sv
// Time-multiplexed scan controller for a common-bus seven-segment display.
// Upstream writes land in a shadow bank; a commit copies the shadow bank into
// the active bank only at a frame boundary so a frame never mixes old and new
// data. Each digit owns a fixed slot that opens with a blank anti-ghost gap and
// is then lit for a duty-controlled fraction of the slot.
module sevenseg_scan_controller
  import sevenseg_pkg::*;
#(
  parameter int  NUM_DIGITS   = 4,
  parameter int  SLOT_CYCLES  = 1024,
  parameter int  BLANK_CYCLES = 16,
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [3:0]            duty,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DW-1:0]         wr_digit,
  input  logic [3:0]            wr_nibble,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_start
);

  localparam int            SW        = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] IDX_LAST  = DW'(NUM_DIGITS - 1);

  scan_state_t           state;
  scan_state_t           state_next;
  logic [SW-1:0]         slot_cnt;
  logic [DW-1:0]         idx;
  logic                  scanning;
  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [3:0]            phase;
  logic                  wr_fire;
  logic                  commit_apply;
  digit_t                shadow_bank [NUM_DIGITS];
  digit_t                active_bank [NUM_DIGITS];
  digit_t                cur_digit;
  logic [7:0]            cur_glyph;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] dig_en_d;
  logic                  frame_start_d;

  // Scanning only counts while enable is still high, so dropping enable darkens
  // the outputs on the very next edge even though the state leaves SCAN then too.
  assign scanning   = (state == ST_SCAN) && enable;
  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = scanning && slot_wrap && (idx == IDX_LAST);

  // The upper four slot-counter bits split the slot into 16 equal PWM steps.
  assign phase = slot_cnt[SW-1 -: 4];

  // Writes stall while a commit waits, so the committed snapshot cannot change
  // underneath it. Out-of-range digit indices are handshaken and then dropped.
  assign wr_ready     = !commit_pending;
  assign wr_fire      = wr_valid && wr_ready && (int'(wr_digit) < NUM_DIGITS);
  assign commit_apply = commit_pending && ((state == ST_IDLE) || frame_wrap);

  assign cur_digit = active_bank[idx];

  sevenseg_glyph_decode u_glyph (
    .digit (cur_digit),
    .seg   (cur_glyph)
  );

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start scanning when enabled, stop as soon as enable is seen low.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (enable)  state_next = ST_SCAN;
      ST_SCAN: if (!enable) state_next = ST_IDLE;
    endcase
  end

  // Slot and digit counters; both sit at zero whenever the scan is not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (scanning) begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SW'(1);
      if (slot_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + DW'(1);
      end
    end else begin
      slot_cnt <= '0;
      idx      <= '0;
    end
  end

  // Decide what the bus shows for the current counter position.
  always_comb begin
    seg_d         = SEG_OFF;
    dig_en_d      = '0;
    frame_start_d = 1'b0;
    if (scanning) begin
      frame_start_d = (slot_cnt == '0) && (idx == '0);
      if ((slot_cnt >= BLANK_END) && (phase <= duty)) begin
        seg_d         = cur_glyph;
        dig_en_d[idx] = 1'b1;
      end
    end
  end

  // Register the display outputs so the pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg         <= SEG_OFF;
      dig_en      <= '0;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_d;
      dig_en      <= dig_en_d;
      frame_start <= frame_start_d;
    end
  end

  // Shadow bank takes accepted upstream writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_bank[i] <= DIGIT_RESET;
      end
    end else if (wr_fire) begin
      shadow_bank[wr_digit] <= '{nibble: wr_nibble, dp: wr_dp, blank: wr_blank};
    end
  end

  // Latch a commit request and copy shadow to active at the next safe point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_pending <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active_bank[i] <= DIGIT_RESET;
      end
    end else if (commit_apply) begin
      commit_pending <= 1'b0;
      active_bank    <= shadow_bank;
    end else if (commit && !commit_pending) begin
      commit_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// Self-checking bench for sevenseg_scan_controller using a frame-time reference
// model: expected bus contents are derived from the elapsed scan time and the
// bank contents, stored directly as the byte the display should show.
module tb_sevenseg_scan_controller;

  localparam int NUM_DIGITS   = 4;
  localparam int SLOT_CYCLES  = 128;
  localparam int BLANK_CYCLES = 4;
  localparam int FRAME        = NUM_DIGITS * SLOT_CYCLES;
  localparam int STEP         = SLOT_CYCLES / 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] duty;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [3:0] wr_nibble;
  logic       wr_dp;
  logic       wr_blank;
  logic       commit;
  logic       commit_pending;
  logic [7:0] seg;
  logic [3:0] dig_en;
  logic       frame_start;

  sevenseg_scan_controller #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .duty           (duty),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_digit       (wr_digit),
    .wr_nibble      (wr_nibble),
    .wr_dp          (wr_dp),
    .wr_blank       (wr_blank),
    .commit         (commit),
    .commit_pending (commit_pending),
    .seg            (seg),
    .dig_en         (dig_en),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  int glyphShapes[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference model state: banks hold the byte each digit should display.
  int mShadow[NUM_DIGITS];
  int mActive[NUM_DIGITS];
  bit mScan    = 1'b0;
  bit mPending = 1'b0;
  int mTime    = 0;
  int expSeg   = 0;
  int expDig   = 0;
  int expFs    = 0;
  int mPos, mDigit, mOff;
  bit mBoundary, mApply;

  int onCount, segNonZero, fsCount;
  int perDigit[NUM_DIGITS];
  int waited;

  function automatic int refGlyph(input int nib, input bit dp, input bit blk);
    return (blk ? 0 : glyphShapes[nib]) + (dp ? 128 : 0);
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model advances on each clock edge from the frame position and the banks.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        mShadow[i] = 0;
        mActive[i] = 0;
      end
      mScan    = 1'b0;
      mPending = 1'b0;
      mTime    = 0;
      expSeg   = 0;
      expDig   = 0;
      expFs    = 0;
    end else begin
      expSeg    = 0;
      expDig    = 0;
      expFs     = 0;
      mBoundary = 1'b0;
      if (mScan && enable) begin
        mPos   = mTime % FRAME;
        mDigit = mPos / SLOT_CYCLES;
        mOff   = mPos % SLOT_CYCLES;
        expFs  = (mPos == 0) ? 1 : 0;
        if (mOff >= BLANK_CYCLES && (mOff / STEP) <= int'(duty)) begin
          expDig = 1 << mDigit;
          expSeg = mActive[mDigit];
        end
        mBoundary = (mPos == FRAME - 1);
      end
      mApply = mPending && (!mScan || mBoundary);
      if (mApply) begin
        for (int i = 0; i < NUM_DIGITS; i++) mActive[i] = mShadow[i];
      end
      if (wr_valid && !mPending && int'(wr_digit) < NUM_DIGITS) begin
        mShadow[wr_digit] = refGlyph(int'(wr_nibble), wr_dp, wr_blank);
      end
      mPending = mPending ? !mApply : commit;
      if (mScan) begin
        if (enable) begin
          mTime++;
        end else begin
          mScan = 1'b0;
          mTime = 0;
        end
      end else if (enable) begin
        mScan = 1'b1;
        mTime = 0;
      end
    end
  end

  task automatic compareAll();
    checkOutput("seg", int'(seg), expSeg);
    checkOutput("dig_en", int'(dig_en), expDig);
    checkOutput("frame_start", int'(frame_start), expFs);
    checkOutput("commit_pending", int'(commit_pending), int'(mPending));
    checkOutput("wr_ready", int'(wr_ready), int'(!mPending));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      compareAll();
    end
  endtask

  task automatic waitFrameStart(input string tag, output int count);
    count = 0;
    do begin
      tick(1);
      count++;
    end while (frame_start !== 1'b1 && count < 2 * FRAME);
    if (frame_start !== 1'b1) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  // Observe one whole frame starting from a frame_start cycle.
  task automatic measureFrame();
    onCount    = 0;
    segNonZero = 0;
    fsCount    = 0;
    for (int b = 0; b < NUM_DIGITS; b++) perDigit[b] = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick(1);
      if (dig_en != 4'd0) onCount++;
      if (seg != 8'd0) segNonZero++;
      if (frame_start) fsCount++;
      for (int b = 0; b < NUM_DIGITS; b++) if (dig_en[b]) perDigit[b]++;
    end
  endtask

  task automatic writeDigit(input int d, input int nib, input bit dp, input bit blk);
    wr_valid  = 1'b1;
    wr_digit  = 2'(d);
    wr_nibble = 4'(nib);
    wr_dp     = dp;
    wr_blank  = blk;
    tick(1);
    wr_valid  = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      wr_valid  = ($urandom_range(0, 3) == 0);
      wr_digit  = 2'($urandom_range(0, 3));
      wr_nibble = 4'($urandom_range(0, 15));
      wr_dp     = 1'($urandom_range(0, 1));
      wr_blank  = ($urandom_range(0, 3) == 0);
      commit    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 199) == 0) duty = 4'($urandom_range(0, 15));
      if (enable && $urandom_range(0, 499) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      tick(1);
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    enable   = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    duty      = 4'd15;
    wr_valid  = 1'b0;
    wr_digit  = 2'd0;
    wr_nibble = 4'd0;
    wr_dp     = 1'b0;
    wr_blank  = 1'b1;
    commit    = 1'b0;
    tick(3);
    checkOutput("reset_seg", int'(seg), 0);
    checkOutput("reset_dig_en", int'(dig_en), 0);
    checkOutput("reset_wr_ready", int'(wr_ready), 1);
    rst = 1'b0;
    tick(2);

    $display("[TB] scan with all digits blank");
    enable = 1'b1;
    waitFrameStart("first_frame", waited);
    checkOutput("first_frame_latency", waited, 2);
    measureFrame();
    checkOutput("full_duty_on_cycles", onCount, 4 * 124);
    for (int b = 0; b < NUM_DIGITS; b++) checkOutput("full_duty_per_digit", perDigit[b], 124);
    checkOutput("blank_seg_dark", segNonZero, 0);
    checkOutput("frame_period_pulses", fsCount, 1);
    checkOutput("frame_period_end", int'(frame_start), 1);

    $display("[TB] writes then commit mid-frame");
    writeDigit(0, 3, 1'b0, 1'b0);
    writeDigit(1, 10, 1'b1, 1'b0);
    tick(100);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    checkOutput("commit_pending_set", int'(commit_pending), 1);
    checkOutput("commit_wr_ready_low", int'(wr_ready), 0);
    waitFrameStart("commit_frame", waited);
    checkOutput("commit_wait_cycles", waited, FRAME - 103);
    checkOutput("commit_cleared", int'(commit_pending), 0);
    tick(10);
    checkOutput("slot0_glyph", int'(seg), 8'h4F);
    checkOutput("slot0_dig_en", int'(dig_en), 1);
    tick(SLOT_CYCLES);
    checkOutput("slot1_glyph", int'(seg), 8'hF7);
    checkOutput("slot1_dig_en", int'(dig_en), 2);

    $display("[TB] brightness steps");
    waitFrameStart("duty_frame", waited);
    duty = 4'd0;
    measureFrame();
    checkOutput("duty0_on_cycles", onCount, 16);
    for (int b = 0; b < NUM_DIGITS; b++) checkOutput("duty0_per_digit", perDigit[b], 4);
    duty = 4'd7;
    measureFrame();
    checkOutput("duty7_on_cycles", onCount, 240);
    duty = 4'd15;

    $display("[TB] write held off by pending commit");
    tick(50);
    commit = 1'b1;
    tick(1);
    commit    = 1'b0;
    wr_valid  = 1'b1;
    wr_digit  = 2'd2;
    wr_nibble = 4'd5;
    wr_dp     = 1'b0;
    wr_blank  = 1'b0;
    waited    = 0;
    while (!wr_ready && waited < 2 * FRAME) begin
      tick(1);
      waited++;
    end
    checkOutput("held_write_cycles", waited, FRAME - 52);
    tick(1);
    wr_valid = 1'b0;
    checkOutput("held_write_taken_at_frame", int'(frame_start), 1);
    tick(2 * SLOT_CYCLES + 10);
    checkOutput("active_unchanged_seg", int'(seg), 0);
    checkOutput("active_unchanged_dig_en", int'(dig_en), 4);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    waitFrameStart("second_commit", waited);
    tick(2 * SLOT_CYCLES + 10);
    checkOutput("slot2_glyph", int'(seg), 8'h6D);

    $display("[TB] disable mid-slot then re-enable");
    enable = 1'b0;
    tick(1);
    checkOutput("disable_dig_en", int'(dig_en), 0);
    checkOutput("disable_seg", int'(seg), 0);
    tick(20);
    enable = 1'b1;
    waitFrameStart("reenable", waited);
    checkOutput("reenable_latency", waited, 2);
    tick(10);
    checkOutput("reenable_slot0_glyph", int'(seg), 8'h4F);

    $display("[TB] randomized traffic");
    applyStimulus(4000);

    $display("[TB] asynchronous reset mid-slot");
    duty   = 4'd15;
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    checkOutput("pending_before_reset", int'(commit_pending), 1);
    tick(40);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_seg", int'(seg), 0);
    checkOutput("async_reset_dig_en", int'(dig_en), 0);
    checkOutput("async_reset_pending", int'(commit_pending), 0);
    tick(1);
    rst = 1'b0;
    waitFrameStart("after_reset", waited);
    measureFrame();
    checkOutput("after_reset_blank", segNonZero, 0);
    checkOutput("after_reset_on_cycles", onCount, 4 * 124);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
